m_cp0: RTL and testbench
========================

Name: m_cp0

Overview:
- Coprocessor-0 exception/interrupt receiver for the 5-stage MIPS pipeline; it sits at the M stage.
- It consumes the exception causes raised upstream, including the E-stage arithmetic overflow, which the pipeline encodes as Ov, and the load/store address-overflow flag, encoded as AdEL/AdES. It also consumes external hardware interrupts.
- It holds SR, Cause and EPC. It raises a single flush/redirect request `req` and supplies EPC for eret.
- It serves mfc0/mtc0 accesses.

Parameters:
- PRID, 32'h0000_0001, constant value returned on reads of register 15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  mtc0 write enable, M stage
- cp0_addr  in  5  CP0 register number for read and write
- cp0_wdata  in  32  mtc0 write data
- cp0_rdata  out  32  mfc0 read data, combinational
- vpc  in  32  PC of the M-stage instruction
- bd_in  in  1  M-stage instruction is in a branch delay slot
- exc_valid  in  1  M-stage instruction carries an exception
- exc_code_in  in  5  ExcCode of that exception
- hw_int  in  6  external interrupt lines, level sensitive
- exl_clr  in  1  eret in M stage
- req  out  1  take exception now; flush pipeline and redirect to 32'h0000_4180
- epc_out  out  32  return address for eret

Behaviour:
- Register fields:
  - SR (12): IM = bits [15:10], EXL = bit 1, IE = bit 0. All other SR bits read 0.
  - Cause (13): BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]. All other Cause bits read 0.
  - EPC (14): full 32 bits.
  - PRId (15): returns PRID.
- Reset: all state registers clear to 0 on a posedge with reset = 1. Consequently req = 0 and cp0_rdata = 0 for registers 12, 13 and 14. Reset overrides every other event in the same cycle.
- Request logic (combinational from current state and inputs):
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_req = exc_valid & ~SR.EXL
  - req = int_req | exc_req
  - Interrupt has priority over a synchronous exception.
- On a posedge with req = 1:
  - EXL <= 1
  - Cause.ExcCode <= 0 if int_req, else exc_code_in
  - Cause.BD <= bd_in
  - EPC <= {vpc[31:2], 2'b00} - (bd_in ? 4 : 0)
  - mtc0 and exl_clr in the same cycle are ignored.
- Cause.IP <= hw_int on every non-reset posedge, regardless of other events. IP is not software-writable.
- mtc0, when en = 1 and req = 0:
  - addr 12: IM, EXL and IE are written from cp0_wdata. Other bits are discarded.
  - addr 14: EPC <= cp0_wdata.
  - addr 13, 15 and all other addresses: the write is ignored.
- exl_clr = 1 with req = 0: EXL <= 0 at the posedge. If en writes SR in the same cycle, the exl_clr result for EXL wins.
- Read: cp0_rdata is combinational on cp0_addr. It returns the register value for 12, 13, 14 and 15, and 0 otherwise.
- epc_out bypass: if en = 1 and cp0_addr = 14, epc_out = cp0_wdata; otherwise epc_out = EPC. This covers an mtc0 EPC immediately followed by eret.
- Nested exceptions: while EXL = 1, neither exceptions nor interrupts assert req. Pending hw_int stays visible in IP.
- Latency: req is asserted in the same cycle as its cause. State updates one cycle later.

Decomposition:
- Shared package: ExcCode constants (Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12), CP0 register numbers (12, 13, 14, 15), the handler address 32'h0000_4180, and SR/Cause field bit positions.
- No sub-module; this is a single flat block.

Test Plan:
- Reset check: assert reset for 2 cycles, then read addrs 12/13/14/15 → 0/0/0/PRID; req = 0.
- Overflow exception: mtc0 SR = 32'h0000_FC01, then exc_valid = 1, code 12, vpc = 32'h3010, bd_in = 0 → req = 1 that cycle. Next cycle: Cause = 32'h0000_0030, EPC = 32'h3010, SR reads 32'h0000_FC03, req = 0 even with exc_valid still high.
- Delay-slot AdES: code 5, vpc = 32'h3024, bd_in = 1 → EPC = 32'h3020, Cause = 32'h8000_0014.
- Interrupt priority: SR = 32'h0000_0401, hw_int = 6'b000001, exc_valid = 1 code 10 in the same cycle → ExcCode = 0, Cause.IP = 6'b000001.
- mtc0 then eret: en = 1, addr 14, wdata 32'h4000 while exl_clr = 1 → epc_out = 32'h4000 that cycle; EXL = 0 next cycle; a masked hw_int (IM = 0) keeps req = 0.
- Reset mid-exception: req and reset both asserted in the same cycle → all registers 0 next cycle; a write to Cause (addr 13) is ignored.

Source files
------------

// File: rtl/m_cp0_pkg.sv
// Shared CP0 constants: exception codes, register numbers, handler vector
// and the SR/Cause field positions.
package m_cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

endpackage

// File: rtl/m_cp0.sv
// M-stage coprocessor 0: holds SR/Cause/EPC, raises the flush/redirect
// request for exceptions and interrupts, and serves mfc0/mtc0.
module m_cp0
  import m_cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_exc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Request decode; interrupt wins over a synchronous exception, EXL blocks both
  always_comb begin
    int_req = (|(hw_int & im)) & ie & ~exl;
    exc_req = exc_valid & ~exl;
    req     = int_req | exc_req;
    // Delay-slot instructions restart at the branch, one word earlier
    epc_exc = (vpc & 32'hFFFF_FFFC) - (bd_in ? 32'd4 : 32'd0);
  end

  // CP0 state update: reset, exception entry, then mtc0 / eret
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? EXC_INT : exc_code_in;
        bd       <= bd_in;
        epc      <= epc_exc;
      end else begin
        if (en && cp0_addr == REG_SR) begin
          im  <= cp0_wdata[SR_IM_LSB +: 6];
          exl <= cp0_wdata[SR_EXL_BIT];
          ie  <= cp0_wdata[SR_IE_BIT];
        end
        if (en && cp0_addr == REG_EPC) begin
          epc <= cp0_wdata;
        end
        // eret clearing EXL takes precedence over a same-cycle SR write
        if (exl_clr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  // Register images and the mfc0 read mux
  always_comb begin
    sr_val                       = '0;
    sr_val[SR_IM_LSB +: 6]       = im;
    sr_val[SR_EXL_BIT]           = exl;
    sr_val[SR_IE_BIT]            = ie;
    cause_val                    = '0;
    cause_val[CAUSE_BD_BIT]      = bd;
    cause_val[CAUSE_IP_LSB +: 6] = ip;
    cause_val[CAUSE_EXC_LSB +: 5] = exc_code;
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_val;
      REG_CAUSE: cp0_rdata = cause_val;
      REG_EPC:   cp0_rdata = epc;
      REG_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = '0;
    endcase
  end

  // Bypass a same-cycle mtc0 EPC so an immediately following eret sees it
  always_comb begin
    epc_out = (en && cp0_addr == REG_EPC) ? cp0_wdata : epc;
  end

endmodule

// File: tb/tb_m_cp0.sv
// Self-checking bench for m_cp0: expected values are queued when stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_m_cp0;
  import m_cp0_pkg::*;

  localparam logic [31:0] PRID = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic        exc_valid;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  m_cp0 #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc),
    .bd_in(bd_in), .exc_valid(exc_valid), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .exl_clr(exl_clr), .req(req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the DUT commits on the rising edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    en       = 1'b0;
    cp0_addr = a;
    #1;
    v = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; cp0_addr = a; cp0_wdata = d;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v, e;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(PRID);
    for (int a = 12; a <= 15; a++) begin
      read_reg(5'(a), v);
      e = exp_q.pop_front();
      total++;
      if (v !== e) begin bad++; $display("FAIL reset_reg%0d: got %h want %h", a, v, e); end
    end
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", req); end
  endtask

  task automatic test_overflow();
    logic [31:0] v, e;
    mtc0(REG_SR, 32'h0000_FC01);
    exc_valid = 1'b1; exc_code_in = EXC_OV; vpc = 32'h3010; bd_in = 1'b0;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL ov_req: got %b want 1", req); end
    tick();
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL ov_nested_req: got %b want 0", req); end
    exp_q.push_back(32'h0000_0030);
    exp_q.push_back(32'h0000_3010);
    exp_q.push_back(32'h0000_FC03);
    read_reg(REG_CAUSE, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ov_cause: got %h want %h", v, e); end
    read_reg(REG_EPC, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ov_epc: got %h want %h", v, e); end
    read_reg(REG_SR, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ov_sr: got %h want %h", v, e); end
    exc_valid = 1'b0;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_delay_slot();
    logic [31:0] v, e;
    exc_valid = 1'b1; exc_code_in = EXC_ADES; vpc = 32'h3024; bd_in = 1'b1;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL ades_req: got %b want 1", req); end
    tick();
    exc_valid = 1'b0; bd_in = 1'b0;
    exp_q.push_back(32'h0000_3020);
    exp_q.push_back(32'h8000_0014);
    read_reg(REG_EPC, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ades_epc: got %h want %h", v, e); end
    read_reg(REG_CAUSE, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL ades_cause: got %h want %h", v, e); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_int_priority();
    logic [31:0] v, e;
    mtc0(REG_SR, 32'h0000_0401);
    hw_int = 6'b000001;
    exc_valid = 1'b1; exc_code_in = EXC_RI; vpc = 32'h5000; bd_in = 1'b0;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL int_req: got %b want 1", req); end
    tick();
    exc_valid = 1'b0;
    exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'h0000_5000);
    read_reg(REG_CAUSE, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL int_cause: got %h want %h", v, e); end
    read_reg(REG_EPC, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL int_epc: got %h want %h", v, e); end
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL int_exl_mask: got %b want 0", req); end
    hw_int = 6'b000000;
  endtask

  task automatic test_mtc0_eret();
    logic [31:0] v, e;
    en = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h0000_4000; exl_clr = 1'b1;
    exp_q.push_back(32'h0000_4000);
    #1;
    e = exp_q.pop_front(); total++;
    if (epc_out !== e) begin bad++; $display("FAIL eret_bypass: got %h want %h", epc_out, e); end
    tick();
    en = 1'b0; exl_clr = 1'b0;
    exp_q.push_back(32'h0000_0401);
    exp_q.push_back(32'h0000_4000);
    read_reg(REG_SR, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL eret_sr: got %h want %h", v, e); end
    e = exp_q.pop_front(); total++;
    if (epc_out !== e) begin bad++; $display("FAIL eret_epc_out: got %h want %h", epc_out, e); end
    mtc0(REG_SR, 32'h0000_0001);
    hw_int = 6'b000010;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL masked_int_req: got %b want 0", req); end
    en = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0403; exl_clr = 1'b1;
    tick();
    en = 1'b0; exl_clr = 1'b0;
    exp_q.push_back(32'h0000_0401);
    read_reg(REG_SR, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL exl_clr_wins: got %h want %h", v, e); end
    hw_int = 6'b000000;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, e;
    exc_valid = 1'b1; exc_code_in = EXC_OV; vpc = 32'h7000; reset = 1'b1;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL rst_mid_req: got %b want 1", req); end
    tick();
    reset = 1'b0; exc_valid = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    for (int a = 12; a <= 14; a++) begin
      read_reg(5'(a), v);
      e = exp_q.pop_front();
      total++;
      if (v !== e) begin bad++; $display("FAIL rst_mid_reg%0d: got %h want %h", a, v, e); end
    end
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL rst_mid_req_after: got %b want 0", req); end
    mtc0(REG_CAUSE, 32'hFFFF_FFFF);
    mtc0(REG_PRID, 32'hDEAD_BEEF);
    mtc0(5'd3, 32'h1234_5678);
    exp_q.push_back(32'h0); exp_q.push_back(PRID); exp_q.push_back(32'h0);
    read_reg(REG_CAUSE, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL cause_ro: got %h want %h", v, e); end
    read_reg(REG_PRID, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL prid_ro: got %h want %h", v, e); end
    read_reg(5'd3, v); e = exp_q.pop_front(); total++;
    if (v !== e) begin bad++; $display("FAIL unmapped_rd: got %h want %h", v, e); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cp0_addr = '0; cp0_wdata = '0; vpc = '0;
    bd_in = 1'b0; exc_valid = 1'b0; exc_code_in = '0; hw_int = '0; exl_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_overflow();
    test_delay_slot();
    test_int_priority();
    test_mtc0_eret();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
